// File: rtl/mprj_pad_cfg_pkg.sv
// Shared mode encodings and apply-sequencer states for the pad configuration controller.
package mprj_pad_cfg_pkg;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_IN    = 2'b01;
  localparam logic [1:0] MODE_OUT   = 2'b10;
  localparam logic [1:0] MODE_BIDIR = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BREAK  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/mprj_pad_cfg_cell.sv
// One managed pad: shadow/active mode registers, change-mask bit and mode decode.
module mprj_pad_cfg_cell
  import mprj_pad_cfg_pkg::*;
#(
  parameter logic [1:0] RESET_MODE = MODE_OFF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_en,
  input  logic [1:0] i_wr_mode,
  input  logic       i_snap,
  input  logic       i_brk,
  input  logic       i_commit,
  input  logic       i_core_out,
  input  logic       i_core_oeb,
  input  logic       i_pad_c,
  output logic       o_core_in,
  output logic       o_pad_i,
  output logic       o_pad_oen,
  output logic       o_pad_ren
);

  logic [1:0] r_shadow;
  logic [1:0] r_active;
  logic       r_mask;
  logic [1:0] w_shadow_nxt;
  logic       w_oen;
  logic       w_ren;
  logic       w_core_in;

  // A write landing in the same cycle as the snapshot must be part of the mask.
  assign w_shadow_nxt = i_wr_en ? i_wr_mode : r_shadow;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow <= RESET_MODE;
      r_active <= RESET_MODE;
      r_mask   <= 1'b0;
    end else begin
      if (i_wr_en) r_shadow <= i_wr_mode;
      if (i_snap) r_mask <= (w_shadow_nxt != r_active);
      if (i_commit && r_mask) r_active <= r_shadow;
    end
  end

  always_comb begin
    w_oen     = 1'b1;
    w_ren     = 1'b0;
    w_core_in = 1'b0;
    case (r_active)
      MODE_IN: begin
        w_ren     = 1'b1;
        w_core_in = i_pad_c;
      end
      MODE_OUT: begin
        w_oen = 1'b0;
        w_ren = 1'b1;
      end
      MODE_BIDIR: begin
        w_oen     = i_core_oeb;
        w_ren     = 1'b1;
        w_core_in = i_pad_c;
      end
      default: ;
    endcase
  end

  assign o_pad_i   = i_core_out;
  assign o_pad_oen = w_oen | (i_brk & r_mask);
  assign o_pad_ren = w_ren;
  assign o_core_in = w_core_in;

endmodule

// File: rtl/mprj_pad_cfg_ctrl.sv
// Pad configuration controller: write decode, settle counter and break-before-make apply FSM.
module mprj_pad_cfg_ctrl
  import mprj_pad_cfg_pkg::*;
#(
  parameter int         N_PADS     = 38,
  parameter int         IDX_W      = 6,
  parameter int         SETTLE_CYC = 4,
  parameter logic [1:0] RESET_MODE = MODE_OFF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [1:0]        cfg_mode,
  output logic              cfg_err,
  input  logic              apply_req,
  output logic              busy,
  output logic              apply_done,
  input  logic [N_PADS-1:0] core_out,
  input  logic [N_PADS-1:0] core_oeb,
  output logic [N_PADS-1:0] core_in,
  input  logic [N_PADS-1:0] pad_c,
  output logic [N_PADS-1:0] pad_i,
  output logic [N_PADS-1:0] pad_oen,
  output logic [N_PADS-1:0] pad_ren
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_accept;
  logic             w_idx_ok;
  logic             w_snap;
  logic             w_brk;
  logic             w_commit;

  assign w_accept = cfg_valid & cfg_ready;
  assign w_idx_ok = (int'(cfg_idx) < N_PADS);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_accept & ~w_idx_ok;
      if (w_snap) r_cnt <= CNT_W'(SETTLE_CYC - 1);
      else if (r_state == BREAK && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_snap      = 1'b0;
    w_brk       = 1'b0;
    w_commit    = 1'b0;
    cfg_ready   = 1'b0;
    busy        = 1'b0;
    apply_done  = 1'b0;
    case (r_state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (apply_req) begin
          w_snap      = 1'b1;
          w_state_nxt = BREAK;
        end
      end
      BREAK: begin
        busy  = 1'b1;
        w_brk = 1'b1;
        if (r_cnt == '0) w_state_nxt = COMMIT;
      end
      COMMIT: begin
        // Keep changing pads released through the commit cycle; active flips at its closing edge.
        busy        = 1'b1;
        w_brk       = 1'b1;
        w_commit    = 1'b1;
        apply_done  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign cfg_err = r_err;

  for (genvar i = 0; i < N_PADS; i++) begin : g_pad
    mprj_pad_cfg_cell #(
      .RESET_MODE(RESET_MODE)
    ) u_cell (
      .i_clk      (wb_clk_i),
      .i_rst      (wb_rst_i),
      .i_wr_en    (w_accept && w_idx_ok && (cfg_idx == IDX_W'(i))),
      .i_wr_mode  (cfg_mode),
      .i_snap     (w_snap),
      .i_brk      (w_brk),
      .i_commit   (w_commit),
      .i_core_out (core_out[i]),
      .i_core_oeb (core_oeb[i]),
      .i_pad_c    (pad_c[i]),
      .o_core_in  (core_in[i]),
      .o_pad_i    (pad_i[i]),
      .o_pad_oen  (pad_oen[i]),
      .o_pad_ren  (pad_ren[i])
    );
  end

endmodule

// File: tb/tb_mprj_pad_cfg_ctrl.sv
// Self-checking bench for mprj_pad_cfg_ctrl: directed scenarios plus random traffic against a mode-table model.
module tb_mprj_pad_cfg_ctrl;

  localparam int         N  = 38;
  localparam int         IW = 6;
  localparam int         SC = 4;
  localparam logic [1:0] RM = 2'b00;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid, cfg_ready, cfg_err, apply_req, busy, apply_done;
  logic [IW-1:0] cfg_idx;
  logic [1:0]    cfg_mode;
  logic [N-1:0]  core_out, core_oeb, core_in, pad_c, pad_i, pad_oen, pad_ren;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: per-pad shadow/active tables, change set and remaining busy cycles.
  logic [1:0] m_sh  [N];
  logic [1:0] m_act [N];
  bit         m_chg [N];
  int         m_left;
  bit         m_err;

  mprj_pad_cfg_ctrl #(
    .N_PADS(N), .IDX_W(IW), .SETTLE_CYC(SC), .RESET_MODE(RM)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx), .cfg_mode(cfg_mode),
    .cfg_err(cfg_err), .apply_req(apply_req), .busy(busy), .apply_done(apply_done),
    .core_out(core_out), .core_oeb(core_oeb), .core_in(core_in), .pad_c(pad_c),
    .pad_i(pad_i), .pad_oen(pad_oen), .pad_ren(pad_ren)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit accept;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_sh[i] = RM; m_act[i] = RM; m_chg[i] = 1'b0;
      end
      m_left = 0;
      m_err  = 1'b0;
    end else begin
      accept = cfg_valid && (m_left == 0);
      m_err  = 1'b0;
      if (accept) begin
        if (int'(cfg_idx) < N) m_sh[cfg_idx] = cfg_mode;
        else m_err = 1'b1;
      end
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0)
          for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
      end else if (apply_req) begin
        for (int i = 0; i < N; i++) m_chg[i] = (m_sh[i] != m_act[i]);
        m_left = SC + 1;
      end
    end
  end

  always @(posedge clk) begin
    logic [N-1:0] e_oen, e_ren, e_cin;
    #2;
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        case (m_act[i])
          2'b00:   begin e_oen[i] = 1'b1;        e_ren[i] = 1'b0; e_cin[i] = 1'b0;     end
          2'b01:   begin e_oen[i] = 1'b1;        e_ren[i] = 1'b1; e_cin[i] = pad_c[i]; end
          2'b10:   begin e_oen[i] = 1'b0;        e_ren[i] = 1'b1; e_cin[i] = 1'b0;     end
          default: begin e_oen[i] = core_oeb[i]; e_ren[i] = 1'b1; e_cin[i] = pad_c[i]; end
        endcase
        if (m_left > 0 && m_chg[i]) e_oen[i] = 1'b1;
      end
      chk("pad_oen", 64'(pad_oen), 64'(e_oen));
      chk("pad_ren", 64'(pad_ren), 64'(e_ren));
      chk("core_in", 64'(core_in), 64'(e_cin));
      chk("pad_i", 64'(pad_i), 64'(core_out));
      chk("ctrl{ready,busy,done,err}", {60'd0, cfg_ready, busy, apply_done, cfg_err},
          {60'd0, m_left == 0, m_left > 0, m_left == 1, m_err});
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    core_out = N'({$urandom(), $urandom()});
    core_oeb = N'({$urandom(), $urandom()});
    pad_c    = N'({$urandom(), $urandom()});
    #1;
  endtask

  task automatic wr(input int idx, input logic [1:0] mode);
    cfg_valid = 1'b1; cfg_idx = IW'(idx); cfg_mode = mode;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic apply_and_wait(output int lat);
    apply_req = 1'b1;
    tick();
    apply_req = 1'b0;
    lat = 1;
    while (!apply_done && lat < 20) begin
      tick();
      lat++;
    end
    tick();
  endtask

  initial begin
    int lat, k;
    logic [N-1:0] ren_before;
    rst = 1'b1; cfg_valid = 1'b0; cfg_idx = '0; cfg_mode = '0; apply_req = 1'b0;
    core_out = '0; core_oeb = '0; pad_c = '0;
    @(negedge clk);

    // T1 reset
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("t1_oen", 64'(pad_oen), 64'({N{1'b1}}));
    chk("t1_ren", 64'(pad_ren), 64'd0);
    chk("t1_core_in", 64'(core_in), 64'd0);
    chk("t1_ready", 64'(cfg_ready), 64'd1);
    chk("t1_busy", 64'(busy), 64'd0);

    // T2 output mode on pad 5
    wr(5, 2'b10);
    apply_req = 1'b1;
    tick();
    apply_req = 1'b0;
    lat = 1; k = 0;
    while (!apply_done && lat < 20) begin
      if (busy) k++;
      tick();
      lat++;
    end
    if (busy) k++;
    chk("t2_latency", 64'(lat), 64'(SC + 1));
    chk("t2_busy_cycles", 64'(k), 64'(SC + 1));
    tick();
    chk("t2_oen5", 64'(pad_oen[5]), 64'd0);
    chk("t2_pad_i5", 64'(pad_i[5]), 64'(core_out[5]));
    chk("t2_oen_others", 64'(pad_oen | (N'(1) << 5)), 64'({N{1'b1}}));
    chk("t2_model_act5", 64'(m_act[5]), 64'd2);

    // T3 break-before-make output -> input
    wr(5, 2'b01);
    apply_req = 1'b1;
    tick();
    apply_req = 1'b0;
    k = 0;
    do begin
      chk("t3_oen5_busy", 64'(pad_oen[5]), 64'd1);
      k++;
      tick();
    end while (busy && k < 20);
    chk("t3_busy_cycles", 64'(k), 64'(SC + 1));
    chk("t3_oen5_after", 64'(pad_oen[5]), 64'd1);
    chk("t3_core_in5", 64'(core_in[5]), 64'(pad_c[5]));

    // T4 out-of-range index
    ren_before = pad_ren;
    wr(40, 2'b10);
    chk("t4_err_pulse", 64'(cfg_err), 64'd1);
    tick();
    chk("t4_err_clear", 64'(cfg_err), 64'd0);
    apply_and_wait(lat);
    chk("t4_latency", 64'(lat), 64'(SC + 1));
    chk("t4_ren_unchanged", 64'(pad_ren), 64'(ren_before));

    // T5 write and second apply during BREAK
    apply_req = 1'b1;
    tick();
    cfg_valid = 1'b1; cfg_idx = IW'(7); cfg_mode = 2'b10;
    tick();
    apply_req = 1'b0;
    chk("t5_ready_in_break", 64'(cfg_ready), 64'd0);
    k = 0;
    while (!apply_done && k < 20) begin
      tick();
      k++;
    end
    chk("t5_done_seen", 64'(apply_done), 64'd1);
    tick();
    chk("t5_ready_after", 64'(cfg_ready), 64'd1);
    tick();
    cfg_valid = 1'b0;
    chk("t5_no_requeue", 64'(busy), 64'd0);
    chk("t5_pad7_not_yet", 64'(pad_oen[7]), 64'd1);
    apply_and_wait(lat);
    chk("t5_pad7_out", 64'(pad_oen[7]), 64'd0);

    // T6 reset mid-BREAK
    wr(5, 2'b10);
    apply_and_wait(lat);
    chk("t6_pre_oen5", 64'(pad_oen[5]), 64'd0);
    wr(9, 2'b01);
    apply_req = 1'b1;
    tick();
    apply_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_oen", 64'(pad_oen), 64'({N{1'b1}}));
    chk("t6_ren", 64'(pad_ren), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    for (int i = 0; i < SC + 2; i++) begin
      chk("t6_no_done", 64'(apply_done), 64'd0);
      tick();
    end

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_idx   = IW'($urandom_range(0, 47));
      cfg_mode  = 2'($urandom());
      apply_req = ($urandom_range(0, 5) == 0);
      tick();
    end
    rst = 1'b0; cfg_valid = 1'b0; apply_req = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
